// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-port memory sequencer.
// MEM_MISALIGN_CHECK_EN (optional) turns misaligned half/word requests into error responses.
package mem_pkg;

   localparam int unsigned MEM_ADDR_W = 10;
   localparam int unsigned MEM_DATA_W = 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned SIZE_W     = 2;

   localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
   localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [SIZE_W-1:0]     size;
      logic                  uns;
      logic [MEM_ADDR_W-1:0] addr;
      logic [WORD_W-1:0]     wdata;
   } req_t;

   // Size 2'b11 behaves as a word, so bit 1 alone selects the two-beat path.
   function automatic logic is_word(input logic [SIZE_W-1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                          input logic [MEM_ADDR_W-1:0] addr);
      return ((size == SIZE_HALF) && addr[0]) || (is_word(size) && (addr[1:0] != 2'b00));
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of little-endian assembled load bytes by access size.
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [WORD_W-1:0] raw,
   input  logic [SIZE_W-1:0] size,
   input  logic              uns,
   output logic [WORD_W-1:0] data_c
);

   always_comb begin
      data_c = raw;
      if (!is_word(size)) begin
         if (size == SIZE_BYTE)
            data_c = {{24{~uns & raw[7]}}, raw[7:0]};
         else
            data_c = {{16{~uns & raw[15]}}, raw[15:0]};
      end
   end

endmodule

// File: rtl/mem_byte_master.sv
// Splits 8/16/32-bit load/store requests into one or two two-byte beats on the RAM byte ports.
// MEM_MISALIGN_CHECK_EN: misaligned half/word requests skip the RAM and respond with rsp_err.
module mem_byte_master
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [SIZE_W-1:0]     req_size,
   input  logic                  req_unsigned,
   input  logic [MEM_ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [WORD_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [MEM_ADDR_W-1:0] ram_addr_a,
   output logic [MEM_ADDR_W-1:0] ram_addr_b,
   output logic [MEM_DATA_W-1:0] ram_wdata_a,
   output logic [MEM_DATA_W-1:0] ram_wdata_b,
   output logic                  ram_we_a,
   output logic                  ram_we_b,
   input  logic [MEM_DATA_W-1:0] ram_rdata_a,
   input  logic [MEM_DATA_W-1:0] ram_rdata_b
);

`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit MISALIGN_EN = 1'b1;
`else
   localparam bit MISALIGN_EN = 1'b0;
`endif

   state_t            state, state_nx;
   req_t              req_q;
   logic [WORD_W-1:0] rbuf_q;
   logic              err_q;
   logic [WORD_W-1:0] ext_c;
   logic              misaligned_c;

   assign misaligned_c = MISALIGN_EN && is_misaligned(req_size, req_addr);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Request latch and read-byte capture at the end of each beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= '0;
         rbuf_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               req_q  <= '{we: req_we, size: req_size, uns: req_unsigned,
                           addr: req_addr, wdata: req_wdata};
               rbuf_q <= '0;
               err_q  <= misaligned_c;
            end
            ST_BEAT0: rbuf_q[15:0]  <= {ram_rdata_b, ram_rdata_a};
            ST_BEAT1: rbuf_q[31:16] <= {ram_rdata_b, ram_rdata_a};
            default: ;
         endcase
      end
   end

   mem_load_ext u_ext (
      .raw    (rbuf_q),
      .size   (req_q.size),
      .uns    (req_q.uns),
      .data_c (ext_c)
   );

   always_comb begin
      state_nx    = state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_rdata   = '0;
      rsp_err     = 1'b0;
      ram_addr_a  = '0;
      ram_addr_b  = '0;
      ram_wdata_a = '0;
      ram_wdata_b = '0;
      ram_we_a    = 1'b0;
      ram_we_b    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = misaligned_c ? ST_RESP : ST_BEAT0;
         end
         ST_BEAT0: begin
            ram_addr_a  = req_q.addr;
            ram_addr_b  = req_q.addr + MEM_ADDR_W'(1);
            ram_wdata_a = req_q.wdata[7:0];
            ram_wdata_b = req_q.wdata[15:8];
            ram_we_a    = req_q.we;
            ram_we_b    = req_q.we && (req_q.size != SIZE_BYTE);
            state_nx    = is_word(req_q.size) ? ST_BEAT1 : ST_RESP;
         end
         ST_BEAT1: begin
            ram_addr_a  = req_q.addr + MEM_ADDR_W'(2);
            ram_addr_b  = req_q.addr + MEM_ADDR_W'(3);
            ram_wdata_a = req_q.wdata[23:16];
            ram_wdata_b = req_q.wdata[31:24];
            ram_we_a    = req_q.we;
            ram_we_b    = req_q.we;
            state_nx    = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = MISALIGN_EN && err_q;
            rsp_rdata = (req_q.we || rsp_err) ? '0 : ext_c;
            state_nx  = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      // Reset takes effect on the outputs in the same cycle, abandoning any beat in flight.
      if (rst) begin
         req_ready   = 1'b0;
         rsp_valid   = 1'b0;
         rsp_rdata   = '0;
         rsp_err     = 1'b0;
         ram_addr_a  = '0;
         ram_addr_b  = '0;
         ram_wdata_a = '0;
         ram_wdata_b = '0;
         ram_we_a    = 1'b0;
         ram_we_b    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_byte_master.sv
// Directed scoreboard bench for mem_byte_master with a behavioural dual-port byte RAM.
// Expectations follow MEM_MISALIGN_CHECK_EN when the bench is built with it defined.
module tb_mem_byte_master;

`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [9:0]  ram_addr_a, ram_addr_b;
   logic [7:0]  ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
   logic        ram_we_a, ram_we_b;

   logic [7:0]  mem [1024];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   logic seen_we, seen_we_b;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
   end
   assign ram_rdata_a = mem[ram_addr_a];
   assign ram_rdata_b = mem[ram_addr_b];

   mem_byte_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
      .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
      .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
      .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, then compare the response against the scoreboard head.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      exp_t e;
      int   lat;
      sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen_we = 1'b0; seen_we_b = 1'b0; lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (ram_we_a || ram_we_b) seen_we = 1'b1;
         if (ram_we_b) seen_we_b = 1'b1;
         if (rsp_valid) begin lat = k; break; end
      end
      e = sb.pop_front();
      if (lat == 0) begin
         checks++; errors++;
         $error("FAIL %s_timeout: observed no rsp_valid expected at cycle %0d", tag, e.lat);
      end else begin
         chk({tag, "_lat"},   32'(lat),     32'(e.lat));
         chk({tag, "_rdata"}, rsp_rdata,    e.rdata);
         chk({tag, "_err"},   32'(rsp_err), 32'(e.err));
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready",  32'(req_ready), 32'd0);
      chk("rst_valid",  32'(rsp_valid), 32'd0);
      chk("rst_we",     32'({ram_we_a, ram_we_b}), 32'd0);
      chk("rst_addr",   32'({ram_addr_a, ram_addr_b}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready",  32'(req_ready), 32'd1);

      // Word store/load round trip, including size 2'b11 as a word.
      do_req("st_w",  1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 3);
      chk("m010", 32'(mem[10'h010]), 32'hEF);
      chk("m011", 32'(mem[10'h011]), 32'hBE);
      chk("m012", 32'(mem[10'h012]), 32'hAD);
      chk("m013", 32'(mem[10'h013]), 32'hDE);
      do_req("ld_w",  1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);
      do_req("ld_w3", 1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

      // Byte sign/zero extension.
      do_req("st_b80", 1'b1, 2'b00, 1'b0, 10'h020, 32'h00000080, 32'h0, 1'b0, 2);
      do_req("ld_bs",  1'b0, 2'b00, 1'b0, 10'h020, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      do_req("ld_bu",  1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 32'h00000080, 1'b0, 2);

      // Half at the top of the address space wraps to 0.
      do_req("clr3ff", 1'b1, 2'b00, 1'b0, 10'h3FF, 32'h0, 32'h0, 1'b0, 2);
      do_req("clr000", 1'b1, 2'b00, 1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 2);
      do_req("st_hw", 1'b1, 2'b01, 1'b0, 10'h3FF, 32'h00001234, 32'h0, MIS, MIS ? 1 : 2);
      chk("st_hw_we", 32'(seen_we), 32'(!MIS));
      chk("m3ff", 32'(mem[10'h3FF]), MIS ? 32'h00 : 32'h34);
      chk("m000", 32'(mem[10'h000]), MIS ? 32'h00 : 32'h12);
      do_req("ld_hw", 1'b0, 2'b01, 1'b1, 10'h3FF, 32'h0, MIS ? 32'h0 : 32'h00001234, MIS, MIS ? 1 : 2);

      // Byte store must not touch the neighbouring byte.
      do_req("st_b55", 1'b1, 2'b00, 1'b0, 10'h006, 32'h00000055, 32'h0, 1'b0, 2);
      do_req("st_bAA", 1'b1, 2'b00, 1'b0, 10'h005, 32'hFFFFFFAA, 32'h0, 1'b0, 2);
      chk("bAA_web", 32'(seen_we_b), 32'd0);
      chk("m005", 32'(mem[10'h005]), 32'hAA);
      chk("m006", 32'(mem[10'h006]), 32'h55);

      // Signed half load.
      do_req("st_h",  1'b1, 2'b01, 1'b0, 10'h040, 32'h00008001, 32'h0, 1'b0, 2);
      do_req("ld_hs", 1'b0, 2'b01, 1'b0, 10'h040, 32'h0, 32'hFFFF8001, 1'b0, 2);

      // Word at a misaligned address.
      do_req("st_wm", 1'b1, 2'b10, 1'b0, 10'h002, 32'h87654321, 32'h0, MIS, MIS ? 1 : 3);
      chk("st_wm_we", 32'(seen_we), 32'(!MIS));
      do_req("ld_wm", 1'b0, 2'b10, 1'b0, 10'h002, 32'h0, MIS ? 32'h0 : 32'h87654321, MIS, MIS ? 1 : 3);

      // Reset during the second beat of a word store.
      do_req("clr100", 1'b1, 2'b10, 1'b0, 10'h100, 32'h0, 32'h0, 1'b0, 3);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 10'h100; req_wdata = 32'h11223344;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b0_we", 32'({ram_we_a, ram_we_b}), 32'h3);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("b1_rst_we",    32'({ram_we_a, ram_we_b}), 32'd0);
      chk("b1_rst_valid", 32'(rsp_valid), 32'd0);
      chk("b1_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rst2_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rec_ready", 32'(req_ready), 32'd1);
      chk("rec_valid", 32'(rsp_valid), 32'd0);
      chk("m100", 32'(mem[10'h100]), 32'h44);
      chk("m101", 32'(mem[10'h101]), 32'h33);
      chk("m102", 32'(mem[10'h102]), 32'h00);
      chk("m103", 32'(mem[10'h103]), 32'h00);
      do_req("ld_rec", 1'b0, 2'b10, 1'b1, 10'h100, 32'h0, 32'h00003344, 1'b0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_byte_master.md
# mem_byte_master

Request-driven sequencer that performs 8/16/32-bit load and store transactions on the byte-wide, 1024-entry dual-port data RAM. It sits between the core's load/store path and the RAM's two byte ports, splitting each request into one or two beats of up to two bytes each (port A = lower byte, port B = next byte). Read data is assembled little-endian and sign- or zero-extended. Completion is signalled with a single-cycle response pulse.

## Interface
- Parameters: none (RAM geometry fixed: 10-bit byte address, 8-bit data).
- Reset is synchronous and active-high; one clock.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and rst low
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  10  byte address of lowest byte
- req_wdata  in  32  store data; byte k written to addr+k
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  32  extended load data, valid with rsp_valid; 0 for stores
- rsp_err  out  1  misalignment error, valid with rsp_valid
- ram_addr_a / ram_addr_b  out  10  byte addresses to RAM ports
- ram_wdata_a / ram_wdata_b  out  8  write bytes
- ram_we_a / ram_we_b  out  1  write enables
- ram_rdata_a / ram_rdata_b  in  8  combinational RAM read data

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1; on req_valid, latch request, go to BEAT0.
- BEAT0: port A addr = a, port B addr = a+1 (mod 1024). Byte: only we_a may assert; we_b=0. Half/word: both ports active. Loads capture rdata_a→byte0, rdata_b→byte1 at cycle end. Next: BEAT1 if word, else RESP.
- BEAT1 (word only): ports at a+2, a+3; bytes 2, 3. Next: RESP.
- RESP: rsp_valid=1, rsp_rdata driven, all ram_we=0; next IDLE.
- Address arithmetic is 10-bit modular: a=1023 word touches 1023, 0, 1, 2.
- Ports never share an address in a beat, so no write collision.
- Extension: byte from bit 7, half from bit 15; word unaffected.
- Stores: ram_wdata carries the relevant req_wdata bytes; rsp_rdata=0.
- Outside BEAT0/BEAT1: ram_we_*=0; ram_addr_*, ram_wdata_* = 0.

## Timing
- Accept at edge where req_valid & req_ready (cycle 0).
- Byte/half: BEAT0 in cycle 1, rsp_valid in cycle 2.
- Word: BEAT0 in cycle 1, BEAT1 in cycle 2, rsp_valid in cycle 3.
- Next request accepted earliest in the cycle after RESP (IDLE).
- Reset values: state IDLE; req_ready=0 while rst high, 1 the cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we_*=0, ram_addr_*=0, ram_wdata_*=0.
- Reset mid-operation: ram_we_* gated by !rst in the same cycle; transaction abandoned, no rsp_valid; partial word store may leave bytes 0–1 written.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 skips BEAT0/BEAT1 (no RAM access, no writes), goes IDLE→RESP; rsp_valid one cycle after accept with rsp_err=1, rsp_rdata=0.
- Undefined: misaligned requests run normally; rsp_err tied 0.

## Structure
- Package mem_pkg: size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), FSM state enum, MEM_ADDR_W=10.
- Sub-module mem_load_ext: combinational sign/zero extension of assembled bytes by size/unsigned.

## Test plan
- Store word 0xDEADBEEF at 0x010, load word 0x010 → rsp_rdata 0xDEADBEEF, rsp_valid at cycle 3 after accept; RAM[0x010..0x013] = EF, BE, AD, DE.
- RAM[0x020]=0x80: load byte signed → 0xFFFFFF80; unsigned → 0x00000080; rsp_valid at cycle 2.
- Store half 0x1234 at 0x3FF → RAM[0x3FF]=34, RAM[0x000]=12; load half unsigned 0x3FF → 0x00001234.
- Store byte 0xAA at 0x005 with RAM[0x006]=0x55 → RAM[0x006] unchanged, we_b never asserted.
- Word store at 0x100, rst asserted in BEAT1 cycle → no we in that cycle, no rsp_valid, req_ready=1 cycle after rst release.
- With MEM_MISALIGN_CHECK_EN: load word at 0x002 → rsp_err=1, rsp_rdata=0, rsp_valid cycle 1, no RAM writes; without: returns bytes 0x002–0x005, rsp_err=0.
